// File: rtl/down_timer_pkg.sv
// Shared definitions for the down-counting timer and related timer blocks:
// FSM state encoding and counting-mode constants.
package down_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_timer_tick_gen.sv
// Prescaler: emits a single-cycle tick once every pre_lim+1 enabled cycles
// while run is high. clr restarts the division from zero. The tick is
// combinational so the owning counter acts on it at the same clock edge.
module down_timer_tick_gen #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      run,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] pre_lim,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] pre_cnt;

  assign tick = run && en && (pre_cnt == pre_lim);

  // Prescaler counter: clears on reset/clr, wraps to zero on each tick, holds when paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= {PRESCALE_WIDTH{1'b0}};
    end else if (clr) begin
      pre_cnt <= {PRESCALE_WIDTH{1'b0}};
    end else if (run && en) begin
      if (pre_cnt == pre_lim) begin
        pre_cnt <= {PRESCALE_WIDTH{1'b0}};
      end else begin
        pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
      end
    end else begin
      pre_cnt <= pre_cnt;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Per-cycle priority is rst > load > stop > start > tick. All outputs are
// registered; tc_pulse marks each terminal-count event for one cycle.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [DATA_WIDTH-1:0]     loadval,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      periodic,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     count,
  output logic                      busy,
  output logic                      tc_pulse,
  output logic                      done
);

  state_t                    state;
  state_t                    state_next;
  logic [DATA_WIDTH-1:0]     count_next;
  logic [DATA_WIDTH-1:0]     reload_reg;
  logic [DATA_WIDTH-1:0]     reload_next;
  logic [PRESCALE_WIDTH-1:0] pre_lim;
  logic [PRESCALE_WIDTH-1:0] pre_lim_next;
  logic                      mode;
  logic                      mode_next;
  logic                      tc_next;
  logic                      clr;
  logic                      tick;
  logic                      is_run;

  assign is_run = (state == ST_RUN);

  down_timer_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .run    (is_run),
    .en     (en),
    .pre_lim(pre_lim),
    .tick   (tick)
  );

  // Next-state, next-count and terminal-pulse decode in priority order.
  always_comb begin
    state_next   = state;
    count_next   = count;
    reload_next  = reload_reg;
    pre_lim_next = pre_lim;
    mode_next    = mode;
    tc_next      = 1'b0;
    clr          = 1'b0;

    case (state)
      ST_IDLE, ST_RUN, ST_DONE: state_next = state;
      default:                  state_next = ST_IDLE;
    endcase

    if (load) begin
      // Load overrides everything else; a coincident tick is dropped.
      count_next  = loadval;
      reload_next = loadval;
      clr         = 1'b1;
      if (state == ST_DONE) begin
        state_next = ST_IDLE;
      end else begin
        state_next = state_next;
      end
    end else if (stop) begin
      // Stop only aborts an active run; count and reload are kept.
      if (is_run) begin
        state_next = ST_IDLE;
        clr        = 1'b1;
      end else begin
        state_next = state_next;
      end
    end else if (start && !is_run) begin
      pre_lim_next = prescale;
      mode_next    = periodic;
      clr          = 1'b1;
      if (count != {DATA_WIDTH{1'b0}}) begin
        state_next = ST_RUN;
      end else begin
        // Zero start value expires immediately with a single pulse.
        state_next = ST_DONE;
        tc_next    = 1'b1;
      end
    end else if (tick) begin
      if (count > DATA_WIDTH'(1)) begin
        count_next = count - DATA_WIDTH'(1);
      end else begin
        // Terminal count; periodic mode reloads instead of showing zero.
        tc_next = 1'b1;
        if (mode == MODE_PERIODIC) begin
          count_next = reload_reg;
        end else begin
          count_next = {DATA_WIDTH{1'b0}};
          state_next = ST_DONE;
        end
      end
    end else begin
      state_next = state_next;
    end
  end

  // State, configuration and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= {DATA_WIDTH{1'b0}};
      reload_reg <= {DATA_WIDTH{1'b0}};
      pre_lim    <= {PRESCALE_WIDTH{1'b0}};
      mode       <= MODE_ONESHOT;
      tc_pulse   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      pre_lim    <= pre_lim_next;
      mode       <= mode_next;
      tc_pulse   <= tc_next;
      busy       <= (state_next == ST_RUN);
      done       <= (state_next == ST_DONE);
    end
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer; the decrementing counterpart of the team's up-counter.
- Loads a start value, counts down on prescaled ticks, and flags terminal count with a one-cycle pulse.
- Supports one-shot and periodic (auto-reload) modes.
- Used for timeouts, periodic event strobes and delay generation alongside the up-counter in the datapath.

Parameters:
DATA_WIDTH, 4, width of count, loadval and reload register
PRESCALE_WIDTH, 8, width of prescale input and internal prescaler counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable; low freezes prescaler and count (pause)
load  input  1  load loadval into count and reload register
loadval  input  DATA_WIDTH  value to load
start  input  1  begin counting from current count
stop  input  1  abort counting, return to IDLE, count holds
periodic  input  1  mode select sampled on start: 1 = auto-reload, 0 = one-shot
prescale  input  PRESCALE_WIDTH  tick divider sampled on start; one tick every prescale+1 enabled cycles
count  output  DATA_WIDTH  current count value, registered
busy  output  1  high in RUN state
tc_pulse  output  1  one-cycle pulse at terminal count, registered
done  output  1  high in DONE state (one-shot expired)

Behaviour:
- Reset: state IDLE; count=0, reload_reg=0, pre_cnt=0, pre_lim=0, mode=0; busy=0, tc_pulse=0, done=0.
- Priority per cycle: rst > load > stop > start > tick.
- States: IDLE, RUN, DONE; busy=(state==RUN), done=(state==DONE).
- load, any state:
  - count<=loadval, reload_reg<=loadval, pre_cnt<=0.
  - RUN stays RUN and counts from the new value.
  - DONE->IDLE; IDLE stays IDLE.
  - A tick coinciding with load is discarded.
- stop:
  - RUN->IDLE; count and reload_reg hold; pre_cnt<=0.
  - No effect in IDLE or DONE.
- start in IDLE or DONE:
  - Latch pre_lim<=prescale and mode<=periodic; pre_cnt<=0.
  - count!=0: ->RUN.
  - count==0: ->DONE with tc_pulse=1 next cycle, in both modes; no continuous pulsing.
- start in RUN: ignored; pre_lim and mode unchanged.
- Prescaler, RUN only, en=1:
  - pre_cnt==pre_lim: tick, pre_cnt<=0.
  - Otherwise pre_cnt<=pre_cnt+1.
  - en=0: pre_cnt and count hold; tc_pulse forced 0.
- Tick in RUN:
  - count>1: count<=count-1.
  - count==1, one-shot: count<=0, tc_pulse<=1, ->DONE.
  - count==1, periodic: count<=reload_reg, tc_pulse<=1, stay RUN; count never shows 0, so the period is reload_reg ticks.
- tc_pulse is high for exactly one cycle per terminal event, else 0.
- Latency (prescale=0, en=1, count=N, start sampled at edge k):
  - First decrement at edge k+1.
  - count=0 and tc_pulse=1 after edge k+N (one-shot).
- Prescale P: ticks at edges k+(P+1), k+2(P+1), …
- Arithmetic is unsigned modulo 2**DATA_WIDTH; decrement never wraps below 0 by construction.
- loadval=0 then start: immediate DONE, as above.
- rst mid-RUN: all state returns to reset values at that edge; no tc_pulse.

Decomposition:
- Shared package/include timer_defs:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module tick_gen: prescaler.
  - Inputs: clk, rst, clr, run, en, pre_lim.
  - Output: tick.
  - clr zeroes pre_cnt; reused by other timer-style blocks.
- FSM and count register live in down_timer.

Test Plan:
- Reset then idle 5 cycles -> count=0, busy=0, done=0, tc_pulse=0 throughout.
- load 3, start (periodic=0, prescale=0), en=1 -> count 2,1,0 on the three following edges; tc_pulse=1 for exactly the cycle count=0 appears; done=1, busy=0 after.
- load 2, start (periodic=1, prescale=2), en=1 -> count decrements every 3 cycles: 2,1,2,1,…; tc_pulse once per 6 cycles at each 1->2 reload; done stays 0.
- load 5, start, en=0 for 4 cycles mid-count, then en=1 -> count frozen while en=0, then resumes; one-shot total 5 enabled ticks before tc_pulse.
- load 4, start, stop after 2 ticks -> IDLE with count=2, busy=0, no tc_pulse; start again -> two more ticks, tc_pulse, done.
- Corner cases:
  - load 0 and start -> tc_pulse next cycle, DONE.
  - rst asserted mid-RUN -> all outputs 0 next edge.
  - load and stop in the same cycle -> load wins: count=loadval, state stays RUN.
